// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter.
// Consumed by counter_mod and counter_prescaler.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Out-of-range load values snap to the top of the count range.
    function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] modulus);
        logic [31:0] res;
        if (val < modulus) begin
            res = val;
        end else begin
            res = modulus - 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: counts en-high cycles 0..PRESCALE-1 and flags the last one.
// Only instantiated when COUNTER_PRESCALE_EN is defined.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clock,
    input  logic clr_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_r;

    assign tick = en & (pre_r == LAST);

    // Prescale phase: cleared by reset/clr, advances and wraps on en, else holds.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            pre_r <= {PW{1'b0}};
        end else if (clr) begin
            pre_r <= {PW{1'b0}};
        end else if (en) begin
            pre_r <= (pre_r == LAST) ? {PW{1'b0}} : pre_r + PW'(1);
        end else begin
            pre_r <= pre_r;
        end
    end

endmodule

// File: rtl/counter_mod.sv
// Parametrised modulo up/down counter with load, wrap/saturate, tc/carry and sticky ovf.
// Optional enable prescaler is built when the COUNTER_PRESCALE_EN macro is defined.
module counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH    = 6,
    parameter int MODULUS  = 64,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 4
) (
    input  logic             clock,
    input  logic             clr_n,
    input  logic             sync_clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             carry,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

    if ((MODULUS < 2) || (longint'(MODULUS) > (longint'(1) << WIDTH)) || (PRESCALE < 1) ||
        ((SATURATE != MODE_WRAP) && (SATURATE != MODE_SAT))) begin : g_bad_param
        $error("counter_mod: illegal parameter combination");
    end

    logic [WIDTH-1:0] count_r;
    logic             ovf_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             ovf_nxt_s;
    logic             step_en_s;
    logic             tc_s;

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock (clock),
        .clr_n (clr_n),
        .clr   (sync_clr | load),
        .en    (en),
        .tick  (step_en_s)
    );
`else
    assign step_en_s = en;
`endif

    assign tc_s  = ((up == DIR_UP) && (count_r == MAX_VAL)) || ((up == DIR_DOWN) && (count_r == ZERO));
    assign tc    = tc_s;
    assign carry = step_en_s & tc_s;
    assign count = count_r;
    assign ovf   = ovf_r;

    // Next-state selection: sync_clr > load > step > hold.
    always_comb begin
        count_nxt_s = count_r;
        ovf_nxt_s   = ovf_r;
        if (sync_clr) begin
            count_nxt_s = ZERO;
            ovf_nxt_s   = 1'b0;
        end else if (load) begin
            count_nxt_s = WIDTH'(clamp_load(32'(load_val), 32'(MODULUS)));
        end else if (step_en_s) begin
            if (up == DIR_UP) begin
                if (count_r == MAX_VAL) begin
                    ovf_nxt_s   = 1'b1;
                    count_nxt_s = (SATURATE == MODE_SAT) ? count_r : ZERO;
                end else begin
                    count_nxt_s = count_r + WIDTH'(1);
                end
            end else begin
                if (count_r == ZERO) begin
                    ovf_nxt_s   = 1'b1;
                    count_nxt_s = (SATURATE == MODE_SAT) ? count_r : MAX_VAL;
                end else begin
                    count_nxt_s = count_r - WIDTH'(1);
                end
            end
        end else begin
            count_nxt_s = count_r;
            ovf_nxt_s   = ovf_r;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            count_r <= ZERO;
            ovf_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

endmodule

// File: tb/tb_counter_mod.sv
// Self-checking bench for counter_mod: a wrapping and a saturating instance share stimulus,
// both are compared against an arithmetic model every cycle, plus hand-computed spot checks.
module tb_counter_mod;

    localparam int W   = 6;
    localparam int MOD = 60;
`ifdef COUNTER_PRESCALE_EN
    localparam int PRE = 4;
`else
    localparam int PRE = 1;
`endif

    logic         clock = 1'b0;
    logic         clr_n;
    logic         sync_clr;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;

    logic [W-1:0] count_w, count_s;
    logic         tc_w, tc_s, carry_w, carry_s, ovf_w, ovf_s;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: index 0 = wrapping instance, 1 = saturating instance.
    int m_cnt [2];
    int m_ovf [2];
    int m_pre;

    always #5 clock = ~clock;

    counter_mod #(.WIDTH(W), .MODULUS(MOD), .SATURATE(0), .PRESCALE(4)) dut_w (
        .clock(clock), .clr_n(clr_n), .sync_clr(sync_clr), .en(en), .up(up),
        .load(load), .load_val(load_val), .count(count_w), .tc(tc_w), .carry(carry_w), .ovf(ovf_w)
    );

    counter_mod #(.WIDTH(W), .MODULUS(MOD), .SATURATE(1), .PRESCALE(4)) dut_s (
        .clock(clock), .clr_n(clr_n), .sync_clr(sync_clr), .en(en), .up(up),
        .load(load), .load_val(load_val), .count(count_s), .tc(tc_s), .carry(carry_s), .ovf(ovf_s)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_step();
        return en && (m_pre == PRE - 1);
    endfunction

    function automatic int model_tc(input int c);
        return (up && c == MOD - 1) || (!up && c == 0);
    endfunction

    // Reference model: plain integer arithmetic on the count range.
    always @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] <= 0;
                m_ovf[k] <= 0;
            end
            m_pre <= 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                int nxt;
                nxt = up ? m_cnt[k] + 1 : m_cnt[k] - 1;
                if (sync_clr) begin
                    m_cnt[k] <= 0;
                    m_ovf[k] <= 0;
                end else if (load) begin
                    m_cnt[k] <= (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
                end else if (model_step()) begin
                    if (nxt < 0 || nxt >= MOD) begin
                        m_ovf[k] <= 1;
                        m_cnt[k] <= (k == 1) ? m_cnt[k] : (nxt + MOD) % MOD;
                    end else begin
                        m_cnt[k] <= nxt;
                    end
                end
            end
            if (sync_clr || load) m_pre <= 0;
            else if (en) m_pre <= (m_pre + 1) % PRE;
        end
    end

    // Per-cycle comparison, after outputs settle following the rising edge.
    always @(posedge clock) begin
        #2;
        check("wrap.count", int'(count_w), m_cnt[0]);
        check("wrap.ovf",   int'(ovf_w),   m_ovf[0]);
        check("wrap.tc",    int'(tc_w),    model_tc(m_cnt[0]));
        check("wrap.carry", int'(carry_w), int'(model_step()) & model_tc(m_cnt[0]));
        check("sat.count",  int'(count_s), m_cnt[1]);
        check("sat.ovf",    int'(ovf_s),   m_ovf[1]);
        check("sat.tc",     int'(tc_s),    model_tc(m_cnt[1]));
        check("sat.carry",  int'(carry_s), int'(model_step()) & model_tc(m_cnt[1]));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        clr_n = 1'b0; sync_clr = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 6'd0;
        tick(2);
        check("reset.count", int'(count_w), 0);
        check("reset.ovf",   int'(ovf_w),   0);
        check("reset.sat",   int'(count_s), 0);
        clr_n = 1'b1; en = 1'b1; up = 1'b1;
`ifndef COUNTER_PRESCALE_EN
        // Up count through the top and wrap.
        tick(59);
        check("up.at59",      int'(count_w), 59);
        check("up.tc59",      int'(tc_w),    1);
        check("up.carry59",   int'(carry_w), 1);
        tick(1);
        check("up.wrap0",     int'(count_w), 0);
        check("up.wrapovf",   int'(ovf_w),   1);
        check("up.sathold",   int'(count_s), 59);
        tick(1);
        check("up.after61",   int'(count_w), 1);
        check("up.sattc",     int'(tc_s),    1);
        // Clear, load clamp, then down wrap.
        sync_clr = 1'b1; tick(1); sync_clr = 1'b0;
        check("clr.ovf",      int'(ovf_w),   0);
        load = 1'b1; load_val = 6'd63; tick(1);
        check("load.clamp",   int'(count_w), 59);
        load_val = 6'd1; tick(1);
        load = 1'b0; up = 1'b0; tick(1);
        check("down.zero",    int'(count_w), 0);
        check("down.tc0",     int'(tc_w),    1);
        check("down.carry0",  int'(carry_w), 1);
        tick(1);
        check("down.wrap59",  int'(count_w), 59);
        check("down.ovf",     int'(ovf_w),   1);
        check("down.satzero", int'(count_s), 0);
        // Saturating run from 57.
        sync_clr = 1'b1; tick(1); sync_clr = 1'b0;
        load = 1'b1; load_val = 6'd57; tick(1);
        load = 1'b0; up = 1'b1; tick(5);
        check("sat.hold59",   int'(count_s), 59);
        check("sat.ovf1",     int'(ovf_s),   1);
        check("sat.tc1",      int'(tc_s),    1);
        check("wrap.past",    int'(count_w), 2);
        // Priority: sync_clr beats load and en; load beats en.
        load = 1'b1; load_val = 6'd30; en = 1'b0; tick(1);
        check("pri.load30",   int'(count_w), 30);
        sync_clr = 1'b1; load_val = 6'd10; en = 1'b1; tick(1);
        check("pri.clr",      int'(count_w), 0);
        check("pri.clrovf",   int'(ovf_w),   0);
        sync_clr = 1'b0; tick(1);
        check("pri.load10",   int'(count_w), 10);
        // Asynchronous reset between edges.
        load_val = 6'd25; tick(1);
        load = 1'b0;
        check("async.pre",    int'(count_w), 25);
        #2 clr_n = 1'b0;
        #1;
        check("async.count",  int'(count_w), 0);
        check("async.sat",    int'(count_s), 0);
        #1 clr_n = 1'b1;
        @(negedge clock);
        check("async.resume", int'(count_w), 1);
        tick(3);
        check("async.run",    int'(count_w), 4);
`else
        // Prescaled stepping: one step per four enabled cycles.
        tick(12);
        check("pre.12",       int'(count_w), 3);
        en = 1'b0; tick(3);
        check("pre.paused",   int'(count_w), 3);
        en = 1'b1; tick(4);
        check("pre.resume",   int'(count_w), 4);
        tick(2);
        load = 1'b1; load_val = 6'd20; tick(1);
        load = 1'b0;
        check("pre.load",     int'(count_w), 20);
        tick(3);
        check("pre.wait",     int'(count_w), 20);
        tick(1);
        check("pre.step",     int'(count_w), 21);
        #2 clr_n = 1'b0;
        #1;
        check("async.count",  int'(count_w), 0);
        #1 clr_n = 1'b1;
        tick(4);
        check("async.resume", int'(count_w), 1);
`endif
        en = 1'b0;
        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/counter_mod.md
Name: counter_mod

Overview:
- Parametrised synchronous modulo up/down counter.
- Generalises the fixed 6-bit enable/clear counter to arbitrary width and modulus.
- Adds direction control, parallel load, wrap or saturate mode, terminal-count/carry outputs for cascading, and a sticky overflow flag.
- Used for processor timers, move/turn counters and cascaded clock-style counters (e.g. seconds/minutes).

Parameters:
- WIDTH, 6, counter width in bits.
- MODULUS, 64, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
- SATURATE, 0, 0 = wrap at the ends, 1 = hold at the ends.
- PRESCALE, 4, enable cycles per count step; used only with COUNTER_PRESCALE_EN; must be >= 1.

Ports:
- clock  in  1  rising-edge clock, single clock domain.
- clr_n  in  1  asynchronous, active-low reset.
- sync_clr  in  1  synchronous clear, highest synchronous priority.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count (registered).
- tc  out  1  terminal count (combinational): (up && count==MODULUS-1) || (!up && count==0).
- carry  out  1  combinational: step_en && tc; feeds en of the next cascaded stage.
- ovf  out  1  sticky overflow/underflow flag (registered).

Behaviour:
- Reset: clr_n low, asynchronously and independent of clock -> count=0, ovf=0, prescaler=0. tc and carry follow from count and inputs.
- Reset release: the first count update happens on the first rising clock edge with clr_n high.
- Synchronous priority per rising edge: sync_clr > load > step_en > hold.
  - sync_clr: count<=0, ovf<=0, prescaler<=0.
  - load: count<=load_val if load_val<MODULUS, else MODULUS-1 (clamped); ovf unchanged; prescaler<=0.
  - step_en: see the stepping rules below.
  - Otherwise: all registers hold.
- step_en:
  - Equals en when COUNTER_PRESCALE_EN is undefined.
  - Otherwise equals en && prescaler==PRESCALE-1.
- Stepping, up=1:
  - count<MODULUS-1: count+1.
  - count==MODULUS-1 with SATURATE=0: count<=0, ovf<=1.
  - count==MODULUS-1 with SATURATE=1: count holds, ovf<=1.
- Stepping, up=0:
  - count>0: count-1.
  - count==0 with SATURATE=0: count<=MODULUS-1, ovf<=1.
  - count==0 with SATURATE=1: count holds, ovf<=1.
- Latency: count reflects a step, load or clear one cycle after the qualifying edge.
- Arithmetic: performed modulo MODULUS in WIDTH bits. No intermediate value exceeds MODULUS-1, and count never leaves the range 0..MODULUS-1.
- up may change on any cycle; tc and carry update combinationally in the same cycle.
- sync_clr together with load or en: sync_clr wins, and ovf is cleared.
- load together with en: load wins and no step occurs that cycle.
- clr_n asserted mid-prescale or mid-sequence: all state returns to reset values immediately.

Optional Feature:
- Macro: COUNTER_PRESCALE_EN.
- Defined:
  - Internal prescaler of width $clog2(PRESCALE) (minimum 1) counts en-high cycles from 0 to PRESCALE-1 and wraps.
  - The counter steps only on the en cycle where the prescaler equals PRESCALE-1.
  - Prescaler holds while en=0.
  - Prescaler is zeroed by clr_n, sync_clr and load.
  - carry is asserted only on the actual step cycle.
  - PRESCALE=1 behaves identically to the macro being undefined.
- Undefined: no prescaler logic is instantiated, step_en=en, and PRESCALE is ignored.

Decomposition:
- Package counter_pkg:
  - Direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0.
  - Mode constants MODE_WRAP=0 and MODE_SAT=1.
  - A function returning the clamped load value.
- Sub-module counter_prescaler:
  - Ports clock, clr_n, clr (sync), en, tick.
  - Instantiated only under COUNTER_PRESCALE_EN.

Test Plan (WIDTH=6, MODULUS=60, SATURATE=0 unless noted):
- Reset and step: clr_n low then high, en=1, up=1 for 61 cycles -> count 0..59; tc=1 and carry=1 at 59; count=0 and ovf=1 after the 60th step; count=1 after the 61st.
- Down wrap and load clamp: load load_val=63 -> count=59. Then up=0, en=1 from count=1 -> 0 then 59; ovf=1 after the wrap.
- Saturate (SATURATE=1): up=1 from 57 for 5 cycles -> 58, 59, 59, 59, 59; ovf=1; tc stays 1.
- Priority: sync_clr=1, load=1 (load_val=10), en=1 at count=30 with ovf=1 -> count=0, ovf=0. Then load=1, en=1 -> count=10.
- Async reset mid-run: clr_n pulsed low between clock edges at count=25 -> count=0 immediately, without waiting for a clock edge; counting resumes from 0.
- Prescale (COUNTER_PRESCALE_EN, PRESCALE=4): en=1 for 12 cycles -> count=3, with carry pulses only on steps. en toggled 0 for 3 cycles mid-run -> no step is lost or gained. load mid-prescale -> the next step occurs 4 en-cycles later.
